// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program image loader for instruction memory
// Receives START, COUNT, COUNT words (big-endian) and an XOR checksum; holds the CPU in reset until a good frame.
module program_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                state, state_next;
  logic [15:0]           count;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [1:0]            byte_cnt;
  logic [23:0]           shift;
  logic [7:0]            chk;
  logic                  accept;
  logic [16:0]           count_full;
  logic                  last_word;
  logic                  is_start;

  assign accept     = rx_valid & rx_ready;
  assign is_start   = (rx_data == START_BYTE);
  assign count_full = {1'b0, count[15:8], rx_data};
  // word_idx still holds the index of the word being completed
  assign last_word  = (17'(word_idx) + 17'd1) == {1'b0, count};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        IDLE, DONE, ERROR: if (is_start) state_next = CNT_HI;
        CNT_HI:            state_next = CNT_LO;
        CNT_LO: begin
          if (count_full == 17'd0)          state_next = CHECK;
          else if (count_full > MAX_WORDS)  state_next = ERROR;
          else                              state_next = DATA;
        end
        DATA:              if (byte_cnt == 2'd3 && last_word) state_next = CHECK;
        CHECK:             state_next = (rx_data == chk) ? DONE : ERROR;
        default:           state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_ready  = ~mem_we;
    done      = (state == DONE);
    error     = (state == ERROR);
    cpu_reset = (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      chk       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (is_start) begin
              count    <= '0;
              word_idx <= '0;
              byte_cnt <= '0;
              chk      <= '0;
            end
          end
          CNT_HI: count[15:8] <= rx_data;
          CNT_LO: count[7:0]  <= rx_data;
          DATA: begin
            chk      <= chk ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {shift, rx_data};
              mem_addr  <= word_idx[ADDR_WIDTH-1:0];
              word_idx  <= word_idx + 1'b1;
            end else begin
              shift <= {shift[15:0], rx_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_model [0:1023];
  int          wr_cnt = 0;
  logic [9:0]  last_addr = '0;
  logic        prev_we = 1'b0;

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory write port model
  always @(posedge clk) begin
    if (mem_we) begin
      mem_model[mem_addr] = mem_wdata;
      last_addr = mem_addr;
      wr_cnt++;
    end
  end

  // every write pulse: single cycle, and rx_ready bubble coincides with it
  always @(negedge clk) begin
    if (mem_we) begin
      check("we_width", {31'd0, prev_we}, 32'd0);
      check("we_bubble", {31'd0, rx_ready}, 32'd0);
    end
    prev_we = mem_we;
  end

  task automatic send(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    while (!rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("rx_ready_timeout", 32'd1, 32'd0);
    @(posedge clk);
  endtask

  task automatic stop();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    stop();
    repeat (2) @(negedge clk);
  endtask

  int base;
  logic [7:0] frame2 [0:11];
  logic [7:0] xr;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);

    // garbage then a one-word frame
    send(8'h00, 0); send(8'hFF, 0); send(8'h13, 0);
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    settle();
    check("f1_wr_cnt", wr_cnt, 32'd1);
    check("f1_addr", {22'd0, last_addr}, 32'd0);
    check("f1_data", mem_model[0], 32'hDEADBEEF);
    check("f1_done_early", {31'd0, done}, 32'd0);
    send(8'h22, 0);
    stop();
    check("f1_done", {31'd0, done}, 32'd1);
    check("f1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("f1_error", {31'd0, error}, 32'd0);

    // two words with random valid gaps
    frame2 = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
               8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    base = wr_cnt;
    for (int i = 0; i < 12; i++) send(frame2[i], $urandom_range(0, 3));
    stop();
    check("f2_done", {31'd0, done}, 32'd1);
    check("f2_wr_cnt", wr_cnt - base, 32'd2);
    check("f2_w0", mem_model[0], 32'h00000001);
    check("f2_w1", mem_model[1], 32'h00000002);
    check("f2_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    // bad checksum: word still written, then error
    base = wr_cnt;
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h00, 0);
    stop();
    check("f3_error", {31'd0, error}, 32'd1);
    check("f3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("f3_done", {31'd0, done}, 32'd0);
    check("f3_wr_cnt", wr_cnt - base, 32'd1);
    check("f3_w0", mem_model[0], 32'h11223344);
    send(8'hA5, 0);
    stop();
    check("f3_rearm_error", {31'd0, error}, 32'd0);
    check("f3_rearm_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // zero-count frame continuing from the re-arm
    base = wr_cnt;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    settle();
    check("f4_done", {31'd0, done}, 32'd1);
    check("f4_wr_cnt", wr_cnt - base, 32'd0);

    // oversize count 1025
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0);
    stop();
    check("f5_error", {31'd0, error}, 32'd1);
    check("f5_done", {31'd0, done}, 32'd0);
    settle();
    check("f5_wr_cnt", wr_cnt - base, 32'd0);

    // reset after two data bytes
    send(8'hA5, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h77, 0); send(8'h66, 0);
    stop();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("r_error", {31'd0, error}, 32'd0);
    check("r_done", {31'd0, done}, 32'd0);
    check("r_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("r_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("r_mem_wdata", mem_wdata, 32'd0);
    check("r_mem_addr", {22'd0, mem_addr}, 32'd0);
    base = wr_cnt;
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'hCA, 0); send(8'hFE, 0); send(8'hBA, 0); send(8'hBE, 0);
    send(8'h30, 0);
    stop();
    check("r_done_after", {31'd0, done}, 32'd1);
    check("r_wr_cnt", wr_cnt - base, 32'd1);
    check("r_addr", {22'd0, last_addr}, 32'd0);
    check("r_w0", mem_model[0], 32'hCAFEBABE);

    // maximum image: 1024 incrementing words
    base = wr_cnt;
    xr   = 8'h00;
    send(8'hA5, 0); send(8'h04, 0); send(8'h00, 0);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = i;
      for (int k = 3; k >= 0; k--) begin
        send(w[k*8 +: 8], 0);
        xr = xr ^ w[k*8 +: 8];
      end
    end
    send(xr, 0);
    stop();
    check("max_done", {31'd0, done}, 32'd1);
    check("max_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("max_wr_cnt", wr_cnt - base, 32'd1024);
    check("max_last_addr", {22'd0, last_addr}, 32'h3FF);
    check("max_w3ff", mem_model[1023], 32'h000003FF);
    check("max_w200", mem_model[512], 32'h00000200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream receiver that loads a program image into instruction memory through its write port, which the processor then reads.
- Holds the processor in reset while loading and releases it only after a complete frame with a valid checksum.
- Sits between a host byte source (UART RX or testbench) and the instruction `ram` write port (`write_enable` / `address` / `data_in`).

Parameters:
- ADDR_WIDTH, 10, instruction memory address width; maximum image size is 2^ADDR_WIDTH words.
- START_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  rx_data holds a byte.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid & rx_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  32  word to write.
- cpu_reset  output  1  processor reset, high while loading or after an error.
- done  output  1  image loaded and checksum OK.
- error  output  1  frame rejected.

Behaviour:
- Reset values:
  - state = IDLE
  - rx_ready = 1, cpu_reset = 1
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
  - done = 0, error = 0
  - internal counters and checksum = 0
- Frame format: START_BYTE, COUNT_HI, COUNT_LO, then COUNT words of 4 bytes each (big-endian, MSB first), then CHK.
  - CHK = XOR of all data bytes only; COUNT bytes are excluded.
- rx_ready is 1 in IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE and ERROR. The only exception is the cycle mem_we is asserted, when rx_ready = 0 (a one-cycle bubble per word).
- States:
  - IDLE: accepted byte == START_BYTE -> CNT_HI, and clear the checksum and word/byte counters. Any other byte is discarded and the state stays IDLE.
  - CNT_HI: latch count[15:8] -> CNT_LO.
  - CNT_LO: latch count[7:0].
    - If count == 0 -> CHECK.
    - Else if count > 2^ADDR_WIDTH -> ERROR.
    - Else -> DATA.
  - DATA:
    - Shift each byte into the assembly register and XOR it into the checksum.
    - On the 4th byte: next cycle mem_we = 1, mem_wdata = assembled word, mem_addr = word index (first word at address 0).
    - Word index increments after each write.
    - After the write of word count-1 -> CHECK.
  - CHECK: accepted byte == checksum -> DONE, else -> ERROR.
  - DONE: done = 1, cpu_reset = 0. An accepted START_BYTE re-arms to CNT_HI with done = 0 and cpu_reset = 1 from the next cycle. Other bytes are ignored.
  - ERROR: error = 1, cpu_reset = 1. An accepted START_BYTE re-arms to CNT_HI with error = 0. Other bytes are ignored.
- mem_we is a registered pulse, exactly 1 cycle wide. mem_addr and mem_wdata are stable while mem_we = 1 and hold their last value otherwise.
- Latency:
  - mem_we asserts 1 cycle after the edge that accepts a word's 4th byte.
  - done/error assert 1 cycle after the edge that accepts CHK.
  - cpu_reset falls together with done.
- rx_valid = 0 stalls any state indefinitely. There is no timeout.
- Words already written before an error remain in memory. They are not rolled back; cpu_reset stays high.
- Maximum image (count == 2^ADDR_WIDTH): the last write is at address 2^ADDR_WIDTH - 1. The internal word counter is ADDR_WIDTH+1 bits so it does not wrap early.
- Bytes inside a frame equal to START_BYTE are treated as data, with no resynchronisation.
- reset asserted mid-frame: on the next edge, every output and all state return to reset values. An in-flight mem_we is dropped.

Test Plan:
- Reset, then frame A5 00 01 DE AD BE EF 22 -> one mem_we pulse with addr 0, wdata 32'hDEADBEEF; next byte 22 gives done = 1, cpu_reset = 0, error = 0.
- Frame A5 00 02 with words 00000001, 00000002 and CHK 03 -> writes addr 0 = 1 and addr 1 = 2, then done. Insert random rx_valid gaps; results must be identical and each write pulse 1 cycle.
- Frame A5 00 01 11 22 33 44 with CHK 00 (expected 44) -> word still written at addr 0, then error = 1, cpu_reset = 1, done = 0. A following A5 clears error.
- Frame A5 00 00 00 -> no mem_we and done = 1. Frame A5 04 01 (count 1025 > 1024) -> ERROR right after COUNT_LO, with no write.
- Garbage bytes 00 FF 13 before A5 are discarded. Asserting reset after 2 data bytes -> outputs return to reset values, and a following valid frame loads from addr 0.
- Count 1024 with incrementing words -> last write at addr 10'h3FF, then done. The rx_ready low cycle coincides with every mem_we.
